// File: rtl/nv_mem_pkg.sv
// Shared defaults, host op encodings and sequencer states for the NV store controller.
package nv_mem_pkg;

    localparam int NV_ADDR_W = 8;
    localparam int NV_DATA_W = 64;
    localparam logic [NV_DATA_W-1:0] NV_ERASE_VAL = {NV_DATA_W{1'b1}};

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_ERASE   = 2'b11
    } nv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_FETCH,
        ST_RD_HOLD,
        ST_ERASE,
        ST_FIN,
        ST_VERIFY
    } nv_state_e;

endpackage

// File: rtl/nv_mem_addr_gen.sv
// Burst address/count register: load, increment with natural wrap, and a last-word flag.
module nv_mem_addr_gen
    import nv_mem_pkg::*;
#(
    parameter int ADDR_W = NV_ADDR_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [ADDR_W-1:0] load_cnt_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            addr_q <= load_addr_i;
            cnt_q  <= load_cnt_i;
        end else if (step_i) begin
            addr_q <= addr_q + 1'b1;
            // The count parks at zero on the final step so last stays asserted until reload.
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/nv_mem_ctrl.sv
// Command sequencer for the non-volatile key/bitstream store (burst read/write, erase-all).
// Define NV_MEM_VERIFY_EN to add a read-back check after every store write.
module nv_mem_ctrl
    import nv_mem_pkg::*;
#(
    parameter int                ADDR_W    = NV_ADDR_W,
    parameter int                DATA_W    = NV_DATA_W,
    parameter logic [DATA_W-1:0] ERASE_VAL = {DATA_W{1'b1}}
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_erase,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    nv_state_e         state_q, state_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ag_load;
    logic [ADDR_W-1:0] ag_load_addr;
    logic [ADDR_W-1:0] ag_load_cnt;
    logic              ag_step;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_last;
`ifdef NV_MEM_VERIFY_EN
    logic [DATA_W-1:0] vdata_q, vdata_d;
    logic              verase_q, verase_d;
`endif

    nv_mem_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk        (fpga_clk),
        .srst       (fpga_rst),
        .load_i     (ag_load),
        .load_addr_i(ag_load_addr),
        .load_cnt_i (ag_load_cnt),
        .step_i     (ag_step),
        .addr_o     (ag_addr),
        .last_o     (ag_last)
    );

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef NV_MEM_VERIFY_EN
            vdata_q    <= '0;
            verase_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef NV_MEM_VERIFY_EN
            vdata_q    <= vdata_d;
            verase_q   <= verase_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        ag_load      = 1'b0;
        ag_load_addr = cmd_addr;
        ag_load_cnt  = cmd_len;
        ag_step      = 1'b0;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        mem_rw       = 1'b0;
        mem_erase    = 1'b0;
        mem_data_in  = '0;
        done         = 1'b0;
`ifdef NV_MEM_VERIFY_EN
        vdata_d      = vdata_q;
        verase_d     = verase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    ag_load = 1'b1;
                    err_d   = 1'b0;
                    case (nv_op_e'(cmd_op))
                        OP_WRITE: state_d = ST_WRITE;
                        OP_READ:  state_d = ST_RD_FETCH;
                        OP_ERASE: begin
                            ag_load_addr = '0;
                            ag_load_cnt  = '1;
                            state_d      = ST_ERASE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_FIN;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                wr_ready    = 1'b1;
                mem_rw      = wr_valid;
                mem_data_in = wr_data;
                if (wr_valid) begin
`ifdef NV_MEM_VERIFY_EN
                    vdata_d  = wr_data;
                    verase_d = 1'b0;
                    state_d  = ST_VERIFY;
`else
                    ag_step = 1'b1;
                    if (ag_last) state_d = ST_FIN;
`endif
                end
            end
            ST_RD_FETCH: begin
                rd_data_d  = mem_data_out;
                rd_valid_d = 1'b1;
                state_d    = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    ag_step    = 1'b1;
                    state_d    = ag_last ? ST_FIN : ST_RD_FETCH;
                end
            end
            ST_ERASE: begin
                mem_erase   = 1'b1;
                mem_rw      = 1'b1;
                mem_data_in = ERASE_VAL;
`ifdef NV_MEM_VERIFY_EN
                vdata_d  = ERASE_VAL;
                verase_d = 1'b1;
                state_d  = ST_VERIFY;
`else
                ag_step = 1'b1;
                if (ag_last) state_d = ST_FIN;
`endif
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef NV_MEM_VERIFY_EN
            // Address is advanced only here, so the store is read back at the word just written.
            ST_VERIFY: begin
                mem_erase = verase_q;
                if (mem_data_out != vdata_q) err_d = 1'b1;
                ag_step = 1'b1;
                if (ag_last)       state_d = ST_FIN;
                else if (verase_q) state_d = ST_ERASE;
                else               state_d = ST_WRITE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_addr_in = ag_addr;

endmodule

// File: tb/tb_nv_mem_ctrl.sv
// Self-checking bench for nv_mem_ctrl: models the store and tracks its expected contents per command.
module tb_nv_mem_ctrl;

    logic        fpga_clk = 1'b0;
    logic        fpga_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_addr = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [63:0] wr_data = 64'h0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [63:0] rd_data;
    logic        busy, done, err, mem_erase, mem_rw;
    logic [7:0]  mem_addr_in;
    logic [63:0] mem_data_in, mem_data_out;

`ifdef NV_MEM_VERIFY_EN
    localparam int EXP_ERASE = 512;
`else
    localparam int EXP_ERASE = 256;
`endif

    always #5 fpga_clk = ~fpga_clk;

    nv_mem_ctrl dut (
        .fpga_clk(fpga_clk), .fpga_rst(fpga_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .mem_erase(mem_erase), .mem_rw(mem_rw), .mem_addr_in(mem_addr_in),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Store model: combinational read, write on the clock edge; flip_arm corrupts bit 0 of a write.
    logic [63:0] store [256];
    logic        flip_arm = 1'b0;
    always @(posedge fpga_clk) begin
        if (mem_rw) store[mem_addr_in] <= mem_data_in ^ {63'b0, flip_arm};
    end
    assign mem_data_out = store[mem_addr_in];

    int done_cnt = 0, rw_cnt = 0, erase_cnt = 0;
    always @(posedge fpga_clk) begin
        if (done)      done_cnt  <= done_cnt + 1;
        if (mem_rw)    rw_cnt    <= rw_cnt + 1;
        if (mem_erase) erase_cnt <= erase_cnt + 1;
    end

    logic [63:0] ref_mem [256];
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [63:0] base;
        logic        exp_err;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] l);
        int t = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && t < 1000) begin @(negedge fpga_clk); t++; end
        check("cmd_ready_wait", {63'b0, cmd_ready}, 64'd1);
        @(posedge fpga_clk);
        @(negedge fpga_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] a, input logic [63:0] d, input int gap);
        int t = 0;
        wr_valid = 1'b0;
        repeat (gap) @(negedge fpga_clk);
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && t < 50) begin @(negedge fpga_clk); t++; end
        check("wr_ready_wait", {63'b0, wr_ready}, 64'd1);
        @(posedge fpga_clk);
        ref_mem[a] = d ^ {63'b0, flip_arm};
        @(negedge fpga_clk);
        wr_valid = 1'b0;
        flip_arm = 1'b0;
    endtask

    task automatic recv_word(input logic [7:0] a, input int stall);
        int t = 0;
        while (!rd_valid && t < 50) begin @(negedge fpga_clk); t++; end
        check("rd_valid_wait", {63'b0, rd_valid}, 64'd1);
        check("rd_data", rd_data, ref_mem[a]);
        repeat (stall) begin
            @(negedge fpga_clk);
            check("rd_hold_data", rd_data, ref_mem[a]);
            check("rd_hold_valid", {63'b0, rd_valid}, 64'd1);
        end
        rd_ready = 1'b1;
        @(posedge fpga_clk);
        @(negedge fpga_clk);
        rd_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (!cmd_ready && t < budget) begin @(negedge fpga_clk); t++; end
        check("idle_wait", {63'b0, cmd_ready}, 64'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] l,
                          input logic [63:0] base, input logic exp_err,
                          input int gap_max, input int stall_max);
        int d0 = done_cnt;
        int r0 = rw_cnt;
        $display("[TB] cmd op=%0d addr=%02h len=%0d", op, a, l);
        issue_cmd(op, a, l);
        if (op == 2'b10) begin
            for (int i = 0; i <= int'(l); i++)
                send_word(a + 8'(i), base + 64'(i), int'($urandom_range(0, gap_max)));
        end else if (op == 2'b01) begin
            for (int i = 0; i <= int'(l); i++)
                recv_word(a + 8'(i), int'($urandom_range(0, stall_max)));
        end
        wait_idle(1000);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("err", {63'b0, err}, {63'b0, exp_err});
        if (op == 2'b10) check("write_count", 64'(rw_cnt - r0), 64'(int'(l) + 1));
        else             check("no_store_write", 64'(rw_cnt - r0), 64'd0);
    endtask

    initial begin
        int d0, r0, e0, mism;
        logic [63:0] x0, x1;

        repeat (3) @(posedge fpga_clk);
        @(negedge fpga_clk);
        check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        check("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_wr_ready", {63'b0, wr_ready}, 64'd0);
        check("rst_mem_rw", {63'b0, mem_rw}, 64'd0);
        check("rst_mem_erase", {63'b0, mem_erase}, 64'd0);
        check("rst_mem_addr", 64'(mem_addr_in), 64'd0);
        fpga_rst = 1'b0;
        @(negedge fpga_clk);

        // Erase-all; its operands must be ignored.
        $display("[TB] cmd erase-all");
        d0 = done_cnt; r0 = rw_cnt; e0 = erase_cnt;
        issue_cmd(2'b11, 8'h33, 8'h05);
        wait_idle(2000);
        check("erase_cycles", 64'(erase_cnt - e0), 64'(EXP_ERASE));
        check("erase_writes", 64'(rw_cnt - r0), 64'd256);
        check("erase_done", 64'(done_cnt - d0), 64'd1);
        check("erase_err", {63'b0, err}, 64'd0);
        check("erase_loc00", store[8'h00], 64'hFFFF_FFFF_FFFF_FFFF);
        check("erase_loc80", store[8'h80], 64'hFFFF_FFFF_FFFF_FFFF);
        check("erase_locFF", store[8'hFF], 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 256; i++) ref_mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;

        vecs[0] = '{2'b01, 8'h00, 8'd0, 64'h0,   1'b0};
        vecs[1] = '{2'b01, 8'h80, 8'd0, 64'h0,   1'b0};
        vecs[2] = '{2'b01, 8'hFF, 8'd0, 64'h0,   1'b0};
        vecs[3] = '{2'b10, 8'h10, 8'd3, 64'hA,   1'b0};
        vecs[4] = '{2'b01, 8'h10, 8'd3, 64'h0,   1'b0};
        vecs[5] = '{2'b10, 8'hFE, 8'd2, 64'h100, 1'b0};
        vecs[6] = '{2'b01, 8'hFE, 8'd2, 64'h0,   1'b0};
        vecs[7] = '{2'b00, 8'h55, 8'd0, 64'h0,   1'b1};
        vecs[8] = '{2'b01, 8'h00, 8'd0, 64'h0,   1'b0};
        for (int v = 0; v < 9; v++)
            do_cmd(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].exp_err, 0, 0);
        check("loc10", store[8'h10], 64'hA);
        check("loc13", store[8'h13], 64'hD);
        check("wrap_loc00", store[8'h00], 64'h102);

        // Read with back-pressure: stalled words must hold their data.
        $display("[TB] cmd read 10 len=3 with stalls");
        d0 = done_cnt;
        issue_cmd(2'b01, 8'h10, 8'd3);
        recv_word(8'h10, 0);
        recv_word(8'h11, 2);
        recv_word(8'h12, 1);
        recv_word(8'h13, 0);
        wait_idle(100);
        check("bp_done", 64'(done_cnt - d0), 64'd1);

        // Reset after 2 of 4 words: no completion, later words untouched.
        $display("[TB] cmd write 40 len=3 aborted by reset");
        d0 = done_cnt; r0 = rw_cnt;
        x0 = 64'h1111_0000_0000_0040; x1 = 64'h1111_0000_0000_0041;
        issue_cmd(2'b10, 8'h40, 8'd3);
        send_word(8'h40, x0, 0);
        send_word(8'h41, x1, 0);
        fpga_rst = 1'b1;
        @(posedge fpga_clk);
        @(negedge fpga_clk);
        fpga_rst = 1'b0;
        check("abort_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check("abort_busy", {63'b0, busy}, 64'd0);
        @(negedge fpga_clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_writes", 64'(rw_cnt - r0), 64'd2);
        check("abort_loc40", store[8'h40], x0);
        check("abort_loc41", store[8'h41], x1);
        check("abort_loc42", store[8'h42], ref_mem[8'h42]);
        check("abort_loc43", store[8'h43], ref_mem[8'h43]);

        // Reset while a read word is pending drops rd_valid.
        $display("[TB] cmd read 10 len=3 aborted by reset");
        issue_cmd(2'b01, 8'h10, 8'd3);
        @(negedge fpga_clk);
        check("rdabort_valid_before", {63'b0, rd_valid}, 64'd1);
        fpga_rst = 1'b1;
        @(posedge fpga_clk);
        @(negedge fpga_clk);
        fpga_rst = 1'b0;
        check("rdabort_valid", {63'b0, rd_valid}, 64'd0);
        check("rdabort_ready", {63'b0, cmd_ready}, 64'd1);

        for (int k = 0; k < 30; k++) begin
            int r = int'($urandom_range(0, 8));
            logic [1:0] op = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : 2'b00;
            do_cmd(op, 8'($urandom), 8'($urandom_range(0, 7)), {$urandom, $urandom},
                   (op == 2'b00), 2, 2);
        end

`ifdef NV_MEM_VERIFY_EN
        $display("[TB] cmd write 20 len=1 with a corrupted store write");
        issue_cmd(2'b10, 8'h20, 8'd1);
        flip_arm = 1'b1;
        send_word(8'h20, 64'h5A5A_0000_0000_0020, 0);
        send_word(8'h21, 64'h5A5A_0000_0000_0021, 0);
        wait_idle(100);
        check("verify_err", {63'b0, err}, 64'd1);
`endif

        mism = 0;
        for (int i = 0; i < 256; i++) if (store[i] !== ref_mem[i]) mism++;
        check("store_scan", 64'(mism), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
